// File: rtl/ram_if.sv
// Bus bundle for the ram word store: one write port (InSel/Input) and one
// combinational read port (OutSel/Output).
interface ram_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] InSel;
    logic [DATA_WIDTH-1:0] Input;
    logic [ADDR_WIDTH-1:0] OutSel;
    logic [DATA_WIDTH-1:0] Output;

    modport master (
        output InSel,
        output Input,
        output OutSel,
        input  Output
    );

    modport slave (
        input  InSel,
        input  Input,
        input  OutSel,
        output Output
    );
endinterface

// File: rtl/ram.sv
// General-purpose datapath word store: 2**ADDR_WIDTH words of DATA_WIDTH bits.
// Every rising Clock edge out of reset writes Input into word InSel (there is
// no enable; callers park InSel on a scratch word). Output is a combinational
// read of word OutSel. Reset_n low clears every word immediately.
module ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input logic  Clock,
    input logic  Reset_n,
    ram_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage: asynchronous clear of all words, otherwise unconditional write.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            mem[bus.InSel] <= bus.Input;
        end
    end

    // Read port: zero-latency view of the addressed word.
    always_comb begin
        bus.Output = mem[bus.OutSel];
    end
endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed scenarios plus a randomized run,
// checked against an array model of the memory contents.
module tb_ram;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;

    logic clk;
    logic rst_n;

    ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    int vectors;
    int errors;
    int unsigned k;
    logic [DW-1:0] model [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: reset empties the store; each clock edge out of reset stores Input at InSel.
    always @(negedge rst_n) begin
        for (int i = 0; i < 256; i++) model[i] = '0;
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) model[bus.InSel] = bus.Input;
    end

    task automatic expect_out(input string name, input logic [DW-1:0] exp);
        vectors++;
        if (bus.Output !== exp) begin
            errors++;
            $display("FAIL %s: OutSel=%0d Output=%h expected=%h", name, bus.OutSel, bus.Output, exp);
        end
    endtask

    task automatic test_reset();
        logic [AW-1:0] sels [3];
        sels[0] = 8'd0; sels[1] = 8'd8; sels[2] = 8'd255;
        bus.InSel = 8'd8;
        bus.Input = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            bus.OutSel = sels[i];
            #1;
            expect_out("reset_read", 32'd0);
        end
        @(posedge clk);
        #1;
        bus.OutSel = 8'd8;
        #1;
        expect_out("reset_blocks_write", 32'd0);
        @(negedge clk);
        bus.InSel = 8'd8;
        bus.Input = 32'd2048;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic step_write(input string name);
        logic [AW-1:0] prev;
        prev = 8'(8 * (k - 1));
        bus.InSel = 8'(8 * k);
        bus.Input = 32'(2048 * k);
        if (k > 1) begin
            bus.OutSel = prev;
            #1;
            vectors++;
            if ($isunknown(bus.Output) || bus.Output !== model[prev]) begin
                errors++;
                $display("FAIL %s: OutSel=%0d Output=%h expected=%h", name, prev, bus.Output, model[prev]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sequential();
        for (k = 1; k <= 31; k++) step_write("read_lag");
        bus.OutSel = 8'd8;   #1; expect_out("seq_addr8", 32'd2048);
        bus.OutSel = 8'd40;  #1; expect_out("seq_addr40", 32'd10240);
        bus.OutSel = 8'd248; #1; expect_out("seq_addr248", 32'd63488);
    endtask

    task automatic test_wrap();
        for (k = 32; k <= 33; k++) step_write("wrap_lag");
        bus.OutSel = 8'd0; #1; expect_out("wrap_addr0", 32'd65536);
        bus.OutSel = 8'd8; #1; expect_out("wrap_addr8", 32'd67584);
        bus.OutSel = 8'd248; #1; expect_out("wrap_addr248", 32'd63488);
    endtask

    task automatic test_same_address();
        logic [DW-1:0] seed;
        seed = $urandom;
        @(negedge clk);
        bus.InSel = 8'd5;
        bus.Input = seed;
        @(posedge clk);
        #1;
        bus.Input = 32'hDEAD_BEEF;
        bus.OutSel = 8'd5;
        #1;
        expect_out("same_addr_before", seed);
        @(posedge clk);
        #1;
        expect_out("same_addr_after", 32'hDEAD_BEEF);
        bus.InSel = 8'd200;
        bus.Input = 32'd0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            bus.InSel  = 8'($urandom);
            bus.Input  = $urandom;
            bus.OutSel = ($urandom_range(0, 3) == 0) ? bus.InSel : 8'($urandom);
            #1;
            expect_out("rand_pre_edge", model[bus.OutSel]);
            @(posedge clk);
            #1;
            expect_out("rand_post_edge", model[bus.OutSel]);
        end
    endtask

    task automatic test_midrun_reset();
        @(negedge clk);
        bus.InSel  = 8'd17;
        bus.Input  = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.OutSel = 8'd17;
        #1;
        expect_out("prereset_value", 32'h1234_5678);
        @(negedge clk);
        bus.Input = 32'd0;
        #1;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset_drop", 32'd0);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < 256; a++) begin
            bus.OutSel = 8'(a);
            #1;
            expect_out("post_reset_sweep", 32'd0);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.InSel  = '0;
        bus.Input  = '0;
        bus.OutSel = '0;
        test_reset();
        test_sequential();
        test_wrap();
        test_same_address();
        test_random();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
